// File: rtl/imem_pkg.sv
// imem_pkg: shared owner encoding, fetch NOP constant and address range check for the instruction memory
package imem_pkg;
  localparam logic [31:0] NOP_INST = 32'h00000013;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DBG} owner_e;
  function automatic logic out_of_range(input logic [31:0] addr, input int unsigned addr_w);
    return (addr >> (addr_w + 2)) != 32'd0;
  endfunction
endpackage

// File: rtl/imem_arbiter.sv
// imem_arbiter: single-port instruction RAM shared by core fetch and debug/loader, debug-first with burst cap
module imem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int MAX_DBG_BURST = 4,
  parameter logic [DATA_W-1:0] NOP_INST = imem_pkg::NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              hold_o,
  input  logic              dbg_halt_i,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [31:0]       dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  import imem_pkg::*;
  localparam int CW = $clog2(MAX_DBG_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_DBG_BURST);
  logic [CW-1:0] burst_q, burst_d;
  owner_e owner_q, owner_d;
  logic oor_q, oor_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dbg_rdata_q, dbg_rdata_d;
  logic if_oor, dbg_oor, fetch_wins;
  always_comb begin
    if_oor = out_of_range(if_addr_i, ADDR_W);
    dbg_oor = out_of_range(dbg_addr_i, ADDR_W);
    // fetch only overrides debug once debug has used up its burst allowance
    fetch_wins = burst_q == BURST_MAX && if_req_i && !dbg_halt_i;
    dbg_gnt_o = !rst && dbg_req_i && !fetch_wins;
    if_gnt_o = !rst && if_req_i && !dbg_halt_i && !dbg_gnt_o;
    hold_o = if_req_i && !if_gnt_o;
    mem_en_o = (dbg_gnt_o && !dbg_oor) || (if_gnt_o && !if_oor);
    mem_we_o = dbg_gnt_o && dbg_we_i && !dbg_oor;
    mem_addr_o = dbg_gnt_o ? dbg_addr_i[ADDR_W+1:2] : if_gnt_o ? if_addr_i[ADDR_W+1:2] : '0;
    mem_wdata_o = dbg_gnt_o ? dbg_wdata_i : '0;
    burst_d = (rst || !if_req_i || if_gnt_o) ? '0
            : (dbg_gnt_o && burst_q != BURST_MAX) ? burst_q + CW'(1) : burst_q;
    owner_d = (dbg_gnt_o && !dbg_we_i) ? OWN_DBG : if_gnt_o ? OWN_IF : OWN_NONE;
    oor_d = dbg_gnt_o ? dbg_oor : if_oor;
    if_rvalid_o = !rst && owner_q == OWN_IF;
    dbg_rvalid_o = !rst && owner_q == OWN_DBG;
    if_rdata_o = rst ? '0 : if_rvalid_o ? (oor_q ? NOP_INST : mem_rdata_i) : if_rdata_q;
    dbg_rdata_o = rst ? '0 : dbg_rvalid_o ? (oor_q ? '0 : mem_rdata_i) : dbg_rdata_q;
    if_rdata_d = if_rdata_o;
    dbg_rdata_d = dbg_rdata_o;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_q <= '0;
      owner_q <= OWN_NONE;
      oor_q <= 1'b0;
      if_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      burst_q <= burst_d;
      owner_q <= owner_d;
      oor_q <= oor_d;
      if_rdata_q <= if_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed vector table plus short sequences against a behavioural single-port sync RAM
module tb_imem_arbiter;
  logic clk = 1'b0;
  logic rst, if_req_i, dbg_halt_i, dbg_req_i, dbg_we_i;
  logic [31:0] if_addr_i, dbg_addr_i, dbg_wdata_i;
  logic if_gnt_o, if_rvalid_o, hold_o, dbg_gnt_o, dbg_rvalid_o, mem_en_o, mem_we_o;
  logic [31:0] if_rdata_o, dbg_rdata_o, mem_wdata_o, mem_rdata_i;
  logic [11:0] mem_addr_o;
  logic [31:0] inst_ram [0:4095];
  int nvec = 0;
  int nbad = 0;
  typedef struct packed {
    logic rst, ir;
    logic [31:0] ia;
    logic h, dr, dw;
    logic [31:0] da, dd;
    logic [4:0] fl;
    logic iv;
    logic [31:0] ird;
    logic dv;
    logic [31:0] drd;
  } vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  imem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .hold_o(hold_o),
    .dbg_halt_i(dbg_halt_i), .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i),
    .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i), .dbg_gnt_o(dbg_gnt_o),
    .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );
  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_we_o) inst_ram[mem_addr_o] <= mem_wdata_o;
      mem_rdata_i <= inst_ram[mem_addr_o];
    end
  end
  task automatic drive(input logic r, ir, input logic [31:0] ia, input logic h, dr, dw,
                       input logic [31:0] da, dd);
    rst = r; if_req_i = ir; if_addr_i = ia; dbg_halt_i = h;
    dbg_req_i = dr; dbg_we_i = dw; dbg_addr_i = da; dbg_wdata_i = dd;
  endtask
  task automatic check(input string name, input logic ok);
    nvec++;
    if (!ok) begin
      nbad++;
      $display("FAIL %s: gnt if/dbg=%b/%b we=%b addr=%h wdata=%h if_rv=%b if_rd=%h dbg_rd=%h",
               name, if_gnt_o, dbg_gnt_o, mem_we_o, mem_addr_o, mem_wdata_o, if_rvalid_o, if_rdata_o, dbg_rdata_o);
    end
  endtask
  initial begin
    logic [71:0] act, exp;
    for (int i = 0; i < 4096; i++) inst_ram[i] = 32'h0;
    inst_ram[0] = 32'h00200513;
    inst_ram[1] = 32'h00158593;
    inst_ram[2] = 32'h00a58633;
    mem_rdata_i = 32'h0;
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    // flags = {if_gnt, dbg_gnt, hold, mem_en, mem_we}
    tbl.push_back('{1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'b00100, 1'b0, 32'h0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'b00000, 1'b0, 32'h0, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'b10010, 1'b0, 32'h0, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'b10010, 1'b1, 32'h00200513, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'b10010, 1'b1, 32'h00158593, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'b00000, 1'b1, 32'h00a58633, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'b00000, 1'b0, 32'h00a58633, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 5'b01111, 1'b0, 32'h00a58633, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'b01110, 1'b0, 32'h00a58633, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'b00100, 1'b0, 32'h00a58633, 1'b1, 32'hDEADBEEF});
    tbl.push_back('{1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'b10010, 1'b0, 32'h00a58633, 1'b0, 32'hDEADBEEF});
    tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'b00000, 1'b1, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF});
    tbl.push_back('{1'b0, 1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 5'b01110, 1'b0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF});
    for (int i = 0; i < 3; i++)
      tbl.push_back('{1'b0, 1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 5'b01110, 1'b0, 32'hDEADBEEF, 1'b1, 32'h00158593});
    tbl.push_back('{1'b0, 1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 5'b10010, 1'b0, 32'hDEADBEEF, 1'b1, 32'h00158593});
    tbl.push_back('{1'b0, 1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 5'b01110, 1'b1, 32'h00a58633, 1'b0, 32'h00158593});
    for (int i = 0; i < 3; i++)
      tbl.push_back('{1'b0, 1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 5'b01110, 1'b0, 32'h00a58633, 1'b1, 32'h00158593});
    tbl.push_back('{1'b0, 1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 5'b10010, 1'b0, 32'h00a58633, 1'b1, 32'h00158593});
    tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'b00000, 1'b1, 32'h00a58633, 1'b0, 32'h00158593});
    tbl.push_back('{1'b0, 1'b1, 32'h10000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'b10000, 1'b0, 32'h00a58633, 1'b0, 32'h00158593});
    tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h10000, 32'hCAFEF00D, 5'b01000, 1'b1, 32'h00000013, 1'b0, 32'h00158593});
    tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h10000, 32'h0, 5'b01000, 1'b0, 32'h00000013, 1'b0, 32'h00158593});
    tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'b00000, 1'b0, 32'h00000013, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 5'b01010, 1'b0, 32'h00000013, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'b00000, 1'b0, 32'h00000013, 1'b1, 32'h00200513});
    tbl.push_back('{1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'b10010, 1'b0, 32'h00000013, 1'b0, 32'h00200513});
    tbl.push_back('{1'b1, 1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'b00100, 1'b0, 32'h0, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'b10010, 1'b0, 32'h0, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'b00000, 1'b1, 32'h00158593, 1'b0, 32'h0});
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].ir, tbl[i].ia, tbl[i].h, tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd);
      #2;
      act = {if_gnt_o, dbg_gnt_o, hold_o, mem_en_o, mem_we_o, if_rvalid_o, if_rdata_o, dbg_rvalid_o, dbg_rdata_o};
      exp = {tbl[i].fl, tbl[i].iv, tbl[i].ird, tbl[i].dv, tbl[i].drd};
      nvec++;
      if (act !== exp) begin
        nbad++;
        $display("FAIL vec%0d: got %h expected %h", i, act, exp);
      end
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 1, 32'h24, 32'h12345678);
    #2 check("dbg_write_port", mem_en_o && mem_we_o && mem_addr_o == 12'd9 && mem_wdata_o == 32'h12345678);
    @(negedge clk);
    drive(0, 1, 32'h24, 0, 0, 0, 0, 0);
    #2 check("fetch_after_write", if_gnt_o && mem_en_o && !mem_we_o && mem_addr_o == 12'd9);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2 check("fetch_new_data", if_rvalid_o && if_rdata_o == 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 1, 0, 0, 0);
    end
    @(negedge clk);
    drive(0, 1, 32'h8, 0, 1, 0, 0, 0);
    #2 check("burst_clear_when_idle", dbg_gnt_o && !if_gnt_o && hold_o);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
